// File: rtl/tone_sequencer.sv
// -----------------------------------------------------------------------------
// tone_sequencer
//   Song controller for tone_generator. Walks a synchronous song ROM of
//   {duration, period} words and drives tone_period/tone_enable note by note.
//   It inserts a silent articulation gap between notes and supports
//   start/stop/pause from the top-level button logic.
//
//   Optional feature macro: TONE_SEQ_LOOP_EN
//     When defined, adds a `loop` level input. With loop=1, an end marker or
//     the last ROM address restarts the song at address 0 without a done pulse.
//
// Ports
//   clk          in   system clock
//   rst_n        in   async active-low reset
//   start        in   1-cycle pulse, begins the song at address 0 (IDLE only)
//   stop         in   abort to IDLE from any state, wins over start/pause
//   pause        in   level, freezes counters/address and silences the output
//   loop         in   (TONE_SEQ_LOOP_EN only) restart instead of finishing
//   rom_addr     out  song ROM address
//   rom_data     in   {dur, period}, valid one cycle after rom_addr
//   tone_period  out  to tone_generator.tone_switch_period
//   tone_enable  out  to tone_generator.output_enable
//   busy         out  high in every state except IDLE
//   done         out  1-cycle pulse at natural song end
//
// State table
//   state   | meaning
//   IDLE    | waiting for start, output silent
//   FETCH   | ROM read latency cycle for rom_addr
//   LATCH   | sample rom_data: end marker or load the note
//   PLAY    | note sounding (silent for period 0), dur*TICK_CYCLES cycles
//   GAP     | silent articulation gap, GAP_CYCLES cycles
//   END     | one-cycle done pulse, then IDLE
// -----------------------------------------------------------------------------
module tone_sequencer #(
    parameter int ADDR_W      = 10,
    parameter int DUR_W       = 8,
    parameter int TICK_CYCLES = 125000,
    parameter int GAP_CYCLES  = 12500
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
`ifdef TONE_SEQ_LOOP_EN
    input  logic              loop,
`endif
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DUR_W+23:0] rom_data,
    output logic [23:0]       tone_period,
    output logic              tone_enable,
    output logic              busy,
    output logic              done
);

    localparam int TICK_W = $clog2(TICK_CYCLES + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

    localparam logic [TICK_W-1:0] TICK_LOAD = TICK_W'(TICK_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_PLAY,
        S_GAP,
        S_END
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [23:0]         period_d;
    logic                enable_d;
    logic                done_d;
    logic [DUR_W-1:0]    note_cnt, note_d;
    logic [TICK_W-1:0]   tick_cnt, tick_d;
    logic [GAP_W-1:0]    gap_cnt, gap_d;
    logic [DUR_W-1:0]    rom_dur;
    logic [23:0]         rom_per;
    logic                loop_en;

    assign rom_dur = rom_data[DUR_W+23:24];
    assign rom_per = rom_data[23:0];

`ifdef TONE_SEQ_LOOP_EN
    assign loop_en = loop;
`else
    assign loop_en = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rom_addr    <= '0;
            tone_period <= '0;
            tone_enable <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            note_cnt    <= '0;
            tick_cnt    <= '0;
            gap_cnt     <= '0;
        end else begin
            state_q     <= state_d;
            rom_addr    <= addr_d;
            tone_period <= period_d;
            tone_enable <= enable_d;
            busy        <= (state_d != S_IDLE);
            done        <= done_d;
            note_cnt    <= note_d;
            tick_cnt    <= tick_d;
            gap_cnt     <= gap_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = rom_addr;
        period_d = tone_period;
        enable_d = tone_enable;
        note_d   = note_cnt;
        tick_d   = tick_cnt;
        gap_d    = gap_cnt;

        if (stop) begin
            state_d  = S_IDLE;
            enable_d = 1'b0;
        end else if (pause && state_q != S_IDLE && state_q != S_END) begin
            // Everything holds; only the output is silenced. END is exempt so
            // done stays a single-cycle pulse.
            enable_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    enable_d = 1'b0;
                    if (start) begin
                        addr_d  = '0;
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: begin
                    state_d = S_LATCH;
                end
                S_LATCH: begin
                    if (rom_dur == '0) begin
                        if (loop_en) begin
                            addr_d  = '0;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_END;
                        end
                    end else begin
                        period_d = rom_per;
                        enable_d = (rom_per != '0);
                        note_d   = rom_dur;
                        tick_d   = TICK_LOAD;
                        state_d  = S_PLAY;
                    end
                end
                S_PLAY: begin
                    // Restores the output after a pause release.
                    enable_d = (tone_period != '0);
                    if (tick_cnt == '0) begin
                        if (note_cnt == DUR_W'(1)) begin
                            enable_d = 1'b0;
                            gap_d    = GAP_LOAD;
                            state_d  = S_GAP;
                        end else begin
                            note_d = note_cnt - 1'b1;
                            tick_d = TICK_LOAD;
                        end
                    end else begin
                        tick_d = tick_cnt - 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == '0) begin
                        if (rom_addr == ADDR_LAST) begin
                            if (loop_en) begin
                                addr_d  = '0;
                                state_d = S_FETCH;
                            end else begin
                                state_d = S_END;
                            end
                        end else begin
                            addr_d  = rom_addr + 1'b1;
                            state_d = S_FETCH;
                        end
                    end else begin
                        gap_d = gap_cnt - 1'b1;
                    end
                end
                S_END: begin
                    enable_d = 1'b0;
                    state_d  = S_IDLE;
                end
                default: begin
                    enable_d = 1'b0;
                    state_d  = S_IDLE;
                end
            endcase
        end

        // END is never held, so done is high for exactly the END cycle.
        done_d = (state_d == S_END);
    end

endmodule
